dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single data memory of the RISC-V core. It shares one synchronous memory port between the CPU load/store path (port 0) and a second requester (port 1, the UART program/data loader). It registers each chosen command, returns read data with a valid pulse, and exposes a stall level that the core uses to freeze the PC while its access is pending.

## Interface
Parameters:
- ADDR_W, 32: byte address width on all ports.
- DATA_W, 32: data width on all ports.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- p0_req  in  1  CPU access request; held until p0_gnt.
- p0_we  in  1  CPU write enable (1 = store, 0 = load).
- p0_addr  in  ADDR_W  CPU byte address.
- p0_wdata  in  DATA_W  CPU store data.
- p0_gnt  out  1  one-cycle pulse: CPU command is on the memory port this cycle.
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid (loads only).
- p0_rdata  out  DATA_W  CPU load data.
- cpu_stall  out  1  p0_req & ~p0_rvalid for loads, p0_req & ~p0_gnt for stores.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for the loader.
- p1_lock  in  1  loader burst lock (only with DMEM_ARB_LOCK_EN; ignored otherwise).
- mem_en  out  1  memory command valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & ~mem_we.

## Operation
- FSM states: IDLE (no command driven), ISSUE0 (port 0 command driven), ISSUE1 (port 1 command driven). Next state is decided every edge from the eligible requests.
- Eligible: pX_req=1 and pX is not being granted in the current cycle. This prevents a still-high request being issued twice.
- Next state:
  - Neither port eligible: IDLE.
  - One port eligible: that port's ISSUE state.
  - Both eligible: the port that is not last_grant.
- last_grant register: updated to X on every entry to ISSUEX; reset value 1, so port 0 wins the first tie.
- ISSUEX drives:
  - mem_en=1, with mem_we/mem_addr/mem_wdata taken from registered copies of port X inputs captured at the deciding edge.
  - pX_gnt=1.
- Read return:
  - A 2-bit pipeline records {issued, port} for reads.
  - In the following cycle, the recorded port's rvalid=1 and its rdata=mem_rdata; the other port's rdata holds its last value.
  - Writes produce no rvalid.
- Throughput: one command per cycle when both ports alternate; a single port issues at most one command every 2 cycles.
- Requesters must hold addr/we/wdata stable while req=1 and gnt=0. After gnt, a requester may present a new request the next cycle.

## Timing
- Request first high at cycle N (edge E_N ends it) → gnt and mem_en at cycle N+1 → rvalid and rdata at cycle N+2. Load latency is 2 cycles and store latency is 1 cycle with no contention.
- Contention adds 1 cycle per lost tie.
- Reset (rst=0 at an edge) forces the following cycle to:
  - state IDLE, last_grant=1;
  - mem_en, mem_we, both gnt and both rvalid = 0;
  - mem_addr, mem_wdata, p0_rdata, p1_rdata = 0.
- Reset mid-operation: a read issued in the cycle before reset produces no rvalid; the pipeline is cleared.
- cpu_stall is combinational from p0_req, p0_we, p0_gnt and p0_rvalid; during reset it equals p0_req.
- Address and data pass through unmodified; no alignment check or wrap is applied.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - When p1_lock=1 and last_grant=1, port 1 wins ties, so a loader burst is not interleaved.
  - Port 0 is still granted whenever port 1 is not eligible, including the cycle after each port 1 grant. Port 0 is therefore never starved by more than 1 consecutive cycle.
- Not defined: p1_lock is unused; pure round-robin as above.

## Test plan
- Single CPU load: rst released, p0_req=1, p0_we=0, p0_addr=0x10, memory returns 0xDEADBEEF → p0_gnt at N+1 with mem_addr=0x10, p0_rvalid at N+2 with p0_rdata=0xDEADBEEF, cpu_stall high for cycles N, N+1.
- Single loader store: p1_req=1, p1_we=1, p1_addr=0x40, p1_wdata=0x12345678 → mem_en=1, mem_we=1, mem_wdata=0x12345678 at N+1, no p1_rvalid.
- Simultaneous first requests after reset, both held → p0 granted at N+1, p1 at N+2, p0 at N+3, strict alternation; each read's rvalid goes only to its owner.
- Reset asserted the cycle after a p0 load grant → p0_rvalid stays 0, all outputs 0 next cycle; the re-asserted request is granted 1 cycle after rst=1.
- Back-to-back p0 only, req held 6 cycles → gnt pulses on alternate cycles (3 pulses), never on consecutive cycles.
- With DMEM_ARB_LOCK_EN, p1_lock=1, both requesting continuously → grants p1, p1, … while p0 is ineligible? No: sequence p1, p0, p1, p0 is not required. Required: a p1 grant whenever both are eligible after a p1 grant, and p0 granted in each cycle following a p1 grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data-memory port between the CPU
// load/store path (port 0) and the UART loader (port 1). Round-robin on
// ties; each chosen command is registered onto the memory port for one
// cycle and read data is returned with a one-cycle valid pulse.
// Optional feature macro: DMEM_ARB_LOCK_EN (p1_lock lets a loader burst win ties).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              cpu_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p1_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_port_q, rd_port_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic elig0, elig1, issue, pick1, tie_pick1;

  // A port already on the memory port this cycle must not be issued again
  assign elig0 = p0_req & (state_q != ISSUE0);
  assign elig1 = p1_req & (state_q != ISSUE1);
  assign issue = elig0 | elig1;

`ifdef DMEM_ARB_LOCK_EN
  // Locked loader keeps winning ties after its own grant
  assign tie_pick1 = ~last_grant_q | (p1_lock & last_grant_q);
`else
  logic unused_p1_lock;
  assign unused_p1_lock = p1_lock;
  assign tie_pick1      = ~last_grant_q;
`endif

  assign pick1 = (elig0 & elig1) ? tie_pick1 : elig1;

  // Next-state, command capture and read-return bookkeeping
  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_vld_d     = mem_en_q & ~mem_we_q;
    rd_port_d    = (state_q == ISSUE1);
    p0_rdata_d   = p0_rdata;
    p1_rdata_d   = p1_rdata;
    if (issue) begin
      state_d      = pick1 ? ISSUE1 : ISSUE0;
      last_grant_d = pick1;
      mem_en_d     = 1'b1;
      mem_we_d     = pick1 ? p1_we    : p0_we;
      mem_addr_d   = pick1 ? p1_addr  : p0_addr;
      mem_wdata_d  = pick1 ? p1_wdata : p0_wdata;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_vld_q     <= 1'b0;
      rd_port_q    <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_vld_q     <= rd_vld_d;
      rd_port_q    <= rd_port_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign p0_gnt    = (state_q == ISSUE0);
  assign p1_gnt    = (state_q == ISSUE1);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rvalid = rd_vld_q & ~rd_port_q;
  assign p1_rvalid = rd_vld_q &  rd_port_q;

  // Memory read data flows through in its valid cycle, otherwise the last value holds
  assign p0_rdata = p0_rvalid ? mem_rdata : p0_rdata_q;
  assign p1_rdata = p1_rvalid ? mem_rdata : p1_rdata_q;

  // PC freeze: loads wait for data, stores only for the grant
  assign cpu_stall = p0_req & (~rst | (p0_we ? ~p0_gnt : ~p0_rvalid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter: one row per clock cycle
// with inputs and expected outputs, plus a hand-written alternation run.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, cpu_stall;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .cpu_stall(cpu_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_lock(p1_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1, lk;
    logic [31:0] a1, d1, md;
  } in_t;

  typedef struct packed {
    logic        g0, g1, v0, v1, en, we;
    logic [31:0] addr, wd, rd0, rd1;
    logic        st;
  } out_t;

  in_t  vin[$];
  out_t vout[$];

  function automatic in_t mi(logic r, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                             logic r1, logic w1, logic lk, logic [31:0] a1, logic [31:0] d1,
                             logic [31:0] md);
    return '{rst:r, r0:r0, w0:w0, a0:a0, d0:d0, r1:r1, w1:w1, lk:lk, a1:a1, d1:d1, md:md};
  endfunction

  function automatic out_t mo(logic g0, logic g1, logic v0, logic v1, logic en, logic we,
                              logic [31:0] addr, logic [31:0] wd, logic [31:0] rd0,
                              logic [31:0] rd1, logic st);
    return '{g0:g0, g1:g1, v0:v0, v1:v1, en:en, we:we, addr:addr, wd:wd, rd0:rd0, rd1:rd1, st:st};
  endfunction

  task automatic add(input in_t i, input out_t o);
    vin.push_back(i);
    vout.push_back(o);
  endtask

  task automatic drive(input in_t i);
    rst = i.rst; p0_req = i.r0; p0_we = i.w0; p0_addr = i.a0; p0_wdata = i.d0;
    p1_req = i.r1; p1_we = i.w1; p1_lock = i.lk; p1_addr = i.a1; p1_wdata = i.d1;
    mem_rdata = i.md;
  endtask

  function automatic out_t sample();
    return '{g0:p0_gnt, g1:p1_gnt, v0:p0_rvalid, v1:p1_rvalid, en:mem_en, we:mem_we,
             addr:mem_addr, wd:mem_wdata, rd0:p0_rdata, rd1:p1_rdata, st:cpu_stall};
  endfunction

  in_t  idle;
  out_t got, exp_o;

  initial begin
    idle = mi(1, 0,0,0,0, 0,0,0,0,0, 0);

    // reset holds outputs low even with a request pending; stall follows p0_req
    add(mi(0, 1,0,32'h99,0, 0,0,0,0,0, 0), mo(0,0,0,0,0,0, 0,0,0,0, 1));
    add(idle,                              mo(0,0,0,0,0,0, 0,0,0,0, 0));
    // single CPU load
    add(mi(1, 1,0,32'h10,0, 0,0,0,0,0, 0), mo(0,0,0,0,0,0, 0,0,0,0, 1));
    add(mi(1, 1,0,32'h10,0, 0,0,0,0,0, 0), mo(1,0,0,0,1,0, 32'h10,0,0,0, 1));
    add(mi(1, 0,0,0,0, 0,0,0,0,0, 32'hDEADBEEF), mo(0,0,1,0,0,0, 32'h10,0,32'hDEADBEEF,0, 0));
    add(mi(1, 0,0,0,0, 0,0,0,0,0, 32'h11111111), mo(0,0,0,0,0,0, 32'h10,0,32'hDEADBEEF,0, 0));
    // single loader store
    add(mi(1, 0,0,0,0, 1,1,0,32'h40,32'h12345678, 0), mo(0,0,0,0,0,0, 32'h10,0,32'hDEADBEEF,0, 0));
    add(mi(1, 0,0,0,0, 1,1,0,32'h40,32'h12345678, 0), mo(0,1,0,0,1,1, 32'h40,32'h12345678,32'hDEADBEEF,0, 0));
    add(idle, mo(0,0,0,0,0,0, 32'h40,32'h12345678,32'hDEADBEEF,0, 0));
    // simultaneous loads, alternating grants, rvalid to owner only
    add(mi(1, 1,0,32'h100,0, 1,0,0,32'h200,0, 0), mo(0,0,0,0,0,0, 32'h40,32'h12345678,32'hDEADBEEF,0, 1));
    add(mi(1, 1,0,32'h100,0, 1,0,0,32'h200,0, 0), mo(1,0,0,0,1,0, 32'h100,0,32'hDEADBEEF,0, 1));
    add(mi(1, 1,0,32'h100,0, 1,0,0,32'h200,0, 32'hA0A0A0A0), mo(0,1,1,0,1,0, 32'h200,0,32'hA0A0A0A0,0, 0));
    add(mi(1, 1,0,32'h100,0, 1,0,0,32'h200,0, 32'hB1B1B1B1), mo(1,0,0,1,1,0, 32'h100,0,32'hA0A0A0A0,32'hB1B1B1B1, 1));
    add(mi(1, 0,0,0,0, 1,0,0,32'h200,0, 32'hC2C2C2C2), mo(0,1,1,0,1,0, 32'h200,0,32'hC2C2C2C2,32'hB1B1B1B1, 0));
    add(mi(1, 0,0,0,0, 0,0,0,0,0, 32'hD3D3D3D3), mo(0,0,0,1,0,0, 32'h200,0,32'hC2C2C2C2,32'hD3D3D3D3, 0));
    add(idle, mo(0,0,0,0,0,0, 32'h200,0,32'hC2C2C2C2,32'hD3D3D3D3, 0));
    // reset during a load grant kills the read return
    add(mi(1, 1,0,32'h300,0, 0,0,0,0,0, 0), mo(0,0,0,0,0,0, 32'h200,0,32'hC2C2C2C2,32'hD3D3D3D3, 1));
    add(mi(0, 1,0,32'h300,0, 0,0,0,0,0, 0), mo(1,0,0,0,1,0, 32'h300,0,32'hC2C2C2C2,32'hD3D3D3D3, 1));
    add(mi(1, 1,0,32'h300,0, 0,0,0,0,0, 32'hEEEEEEEE), mo(0,0,0,0,0,0, 0,0,0,0, 1));
    add(mi(1, 1,0,32'h300,0, 0,0,0,0,0, 0), mo(1,0,0,0,1,0, 32'h300,0,0,0, 1));
    add(mi(1, 0,0,0,0, 0,0,0,0,0, 32'h0BADF00D), mo(0,0,1,0,0,0, 32'h300,0,32'h0BADF00D,0, 0));
    // p0 stores held 6 cycles: grants on alternate cycles only
    for (int k = 0; k < 6; k++)
      add(mi(1, 1,1,32'h500,32'h55, 0,0,0,0,0, 0),
          (k % 2 == 1) ? mo(1,0,0,0,1,1, 32'h500,32'h55,32'h0BADF00D,0, 0)
                       : mo(0,0,0,0,0,0, (k == 0) ? 32'h300 : 32'h500,
                            (k == 0) ? 32'h0 : 32'h55, 32'h0BADF00D,0, 1));
    add(idle, mo(0,0,0,0,0,0, 32'h500,32'h55,32'h0BADF00D,0, 0));
    // p1 store leaves last_grant=1, then a tie with p1_lock=1
    add(mi(1, 0,0,0,0, 1,1,0,32'h600,32'h66, 0), mo(0,0,0,0,0,0, 32'h500,32'h55,32'h0BADF00D,0, 0));
    add(mi(1, 0,0,0,0, 1,1,0,32'h600,32'h66, 0), mo(0,1,0,0,1,1, 32'h600,32'h66,32'h0BADF00D,0, 0));
    add(mi(1, 1,0,32'h700,0, 1,1,1,32'h800,32'h88, 0), mo(0,0,0,0,0,0, 32'h600,32'h66,32'h0BADF00D,0, 1));
`ifdef DMEM_ARB_LOCK_EN
    add(mi(1, 1,0,32'h700,0, 1,1,1,32'h800,32'h88, 0), mo(0,1,0,0,1,1, 32'h800,32'h88,32'h0BADF00D,0, 1));
    add(mi(1, 1,0,32'h700,0, 1,1,1,32'h800,32'h88, 0), mo(1,0,0,0,1,0, 32'h700,0,32'h0BADF00D,0, 1));
    add(mi(1, 0,0,0,0, 1,1,1,32'h800,32'h88, 32'h77777777), mo(0,1,1,0,1,1, 32'h800,32'h88,32'h77777777,0, 0));
`else
    add(mi(1, 1,0,32'h700,0, 1,1,1,32'h800,32'h88, 0), mo(1,0,0,0,1,0, 32'h700,0,32'h0BADF00D,0, 1));
    add(mi(1, 0,0,0,0, 1,1,1,32'h800,32'h88, 32'h77777777), mo(0,1,1,0,1,1, 32'h800,32'h88,32'h77777777,0, 0));
    add(idle, mo(0,0,0,0,0,0, 32'h800,32'h88,32'h77777777,0, 0));
`endif
    add(idle, mo(0,0,0,0,0,0, 32'h800,32'h88,32'h77777777,0, 0));

    // preamble reset
    drive(mi(0, 0,0,0,0, 0,0,0,0,0, 0));
    repeat (2) @(posedge clk);

    // table: drive just after an edge, compare on the falling edge
    for (int i = 0; i < vin.size(); i++) begin
      #1 drive(vin[i]);
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== vout[i]) begin
        failures++;
        $display("FAIL row%0d got=%h exp=%h", i, got, vout[i]);
      end
      @(posedge clk);
    end

    // both ports hold loads: strict alternation starting with p0, data to owner
    for (int k = 0; k < 10; k++) begin
      #1 drive(mi(1, 1,0,32'hA00,0, 1,0,0,32'hB00,0, 32'hF0000000 + 32'(k)));
      @(negedge clk);
      exp_o = mo(0,0,0,0,0,0, 32'h800,32'h88,32'h77777777,0, 1);
      if (k >= 1) begin
        exp_o.en   = 1'b1;
        exp_o.g0   = (k % 2 == 1);
        exp_o.g1   = (k % 2 == 0);
        exp_o.addr = (k % 2 == 1) ? 32'hA00 : 32'hB00;
        exp_o.wd   = 32'h0;
      end
      if (k >= 2) begin
        exp_o.v0 = (k % 2 == 0);
        exp_o.v1 = (k % 2 == 1);
      end
      if (k >= 2) exp_o.rd0 = 32'hF0000000 + 32'((k % 2 == 0) ? k : k - 1);
      if (k >= 3) exp_o.rd1 = 32'hF0000000 + 32'((k % 2 == 1) ? k : k - 1);
      exp_o.st = ~exp_o.v0;
      got = sample();
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL alt%0d got=%h exp=%h", k, got, exp_o);
      end
      @(posedge clk);
    end

    #1 drive(idle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
